// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB power-up configuration sequencer:
// FSM state encoding, table entry layout and SCCB constants.
package sccb_pkg;

  localparam int unsigned ENTRY_W    = 17;
  localparam logic [7:0]  DLY_MARK   = 8'hFF;
  localparam logic [7:0]  SCCB_WR_ID = 8'h42;
  localparam logic [7:0]  SCCB_RD_ID = 8'h43;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR_DLY,
    ST_FETCH,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DLY,
    ST_NEXT,
    ST_DONE
  } cfg_state_e;

  typedef struct packed {
    logic       vfy;
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  function automatic logic [ENTRY_W-1:0] cfg_entry(input logic vfy,
                                                   input logic [7:0] addr,
                                                   input logic [7:0] data);
    return {vfy, addr, data};
  endfunction

endpackage

// File: rtl/sccb_cfg_table.sv
// Register table ROM for the camera power-up sequence.
// Unlisted indices read back as a zero-length delay entry.
module sccb_cfg_table
  import sccb_pkg::*;
(
  input  logic [7:0]         idx,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = cfg_entry(1'b0, DLY_MARK, 8'h00);
    case (idx)
      8'd0:  entry = cfg_entry(1'b0, 8'h12, 8'h80);   // COM7 soft reset
      8'd1:  entry = cfg_entry(1'b0, DLY_MARK, 8'd2); // settle after soft reset
      8'd2:  entry = cfg_entry(1'b1, 8'h3A, 8'h04);
      8'd3:  entry = cfg_entry(1'b0, 8'h40, 8'hD0);
      8'd4:  entry = cfg_entry(1'b1, 8'h8C, 8'h00);
      8'd5:  entry = cfg_entry(1'b0, 8'h11, 8'h01);
      8'd6:  entry = cfg_entry(1'b0, 8'h0C, 8'h00);
      8'd7:  entry = cfg_entry(1'b0, 8'h3E, 8'h00);
      8'd8:  entry = cfg_entry(1'b0, 8'h70, 8'h3A);
      8'd9:  entry = cfg_entry(1'b0, 8'h71, 8'h35);
      8'd10: entry = cfg_entry(1'b0, 8'h72, 8'h11);
      8'd11: entry = cfg_entry(1'b0, 8'h73, 8'hF0);
      8'd12: entry = cfg_entry(1'b0, 8'hA2, 8'h02);
      8'd13: entry = cfg_entry(1'b1, 8'h15, 8'h00);
      default: ;
    endcase
  end

endmodule

// File: rtl/sccb_cfg_ctrl.sv
// Power-up configuration sequencer: walks sccb_cfg_table, writes each entry
// through the SCCB master handshake, optionally verifies by read-back.
module sccb_cfg_ctrl
  import sccb_pkg::*;
#(
  parameter int unsigned REG_NUM    = 165,
  parameter int unsigned MS_CYC     = 25000,
  parameter int unsigned PWR_MS     = 20,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned AUTO_START = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rdy,
  input  logic [7:0] rdata,
  input  logic       rdata_vld,
  output logic       ren,
  output logic       wen,
  output logic [7:0] sub_addr,
  output logic [7:0] wdata,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [7:0] err_idx
);

  localparam int unsigned  CYC_W      = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MS_CYC - 1);
  localparam logic [7:0]   IDX_LAST   = 8'(REG_NUM - 1);
  localparam logic [7:0]   PWR_TGT    = 8'(PWR_MS);
  localparam logic [1:0]   RETRY_LAST = 2'(MAX_RETRY - 1);

  cfg_state_e state, state_nxt;

  logic [ENTRY_W-1:0] entry_raw;
  cfg_entry_t         entry_s;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [7:0]         ms_cnt;
  logic [7:0]         ms_tgt;
  logic [7:0]         idx;
  logic [1:0]         retry;
  logic               vfy;
  logic               auto_go;
  logic               go;
  logic               dly_exp;
  logic               rd_match;

  sccb_cfg_table u_table (
    .idx   (idx),
    .entry (entry_raw)
  );

  assign entry_s  = cfg_entry_t'(entry_raw);
  assign go       = start | auto_go;
  assign ms_tgt   = (state == ST_PWR_DLY) ? PWR_TGT : wdata;
  assign dly_exp  = (ms_cnt == ms_tgt);
  assign rd_match = (rdata == wdata);
  assign cfg_busy = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (go) state_nxt = ST_PWR_DLY;
      ST_PWR_DLY: if (dly_exp) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = (entry_s.addr == DLY_MARK) ? ST_DLY : ST_WR_REQ;
      ST_WR_REQ:  if (rdy) state_nxt = ST_WR_WAIT;
      // wen is registered, so the master's busy indication lags by a cycle
      ST_WR_WAIT: if (!wen && rdy) state_nxt = vfy ? ST_RD_REQ : ST_NEXT;
      ST_RD_REQ:  if (rdy) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (rdata_vld) begin
          if (!rd_match && (retry < RETRY_LAST)) state_nxt = ST_WR_REQ;
          else                                   state_nxt = ST_NEXT;
        end
      end
      ST_DLY:     if (dly_exp) state_nxt = ST_NEXT;
      ST_NEXT:    state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_FETCH;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen      <= 1'b0;
      ren      <= 1'b0;
      sub_addr <= '0;
      wdata    <= '0;
      vfy      <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      err_idx  <= '0;
      idx      <= '0;
      retry    <= '0;
      auto_go  <= (AUTO_START != 0);
      cyc_cnt  <= '0;
      ms_cnt   <= '0;
    end else begin
      wen <= (state == ST_WR_REQ) && rdy;
      ren <= (state == ST_RD_REQ) && rdy;
      if (state == ST_IDLE) auto_go <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (go) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_idx  <= '0;
            idx      <= '0;
            retry    <= '0;
          end
        end
        ST_FETCH: begin
          sub_addr <= entry_s.addr;
          wdata    <= entry_s.data;
          vfy      <= entry_s.vfy;
        end
        ST_RD_WAIT: begin
          if (rdata_vld && !rd_match) begin
            if (retry < RETRY_LAST) begin
              retry <= retry + 2'd1;
            end else begin
              cfg_err <= 1'b1;
              if (!cfg_err) err_idx <= idx;
            end
          end
        end
        ST_NEXT: begin
          retry <= '0;
          if (idx == IDX_LAST) cfg_done <= 1'b1;
          else                 idx      <= idx + 8'd1;
        end
        default: ;
      endcase

      // ms timebase runs only in the two delay states and stops at the target
      if ((state == ST_PWR_DLY || state == ST_DLY) && !dly_exp) begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt <= '0;
          if (ms_cnt != 8'hFF) ms_cnt <= ms_cnt + 8'd1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end else begin
        cyc_cnt <= '0;
        ms_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Directed bench for sccb_cfg_ctrl with a behavioural SCCB master and a
// transaction scoreboard fed with the expected write/read sequence.
module tb_sccb_cfg_ctrl;

  localparam int unsigned REG_NUM   = 5;
  localparam int unsigned MS_CYC    = 10;
  localparam int unsigned PWR_MS    = 2;
  localparam int unsigned MAX_RETRY = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rdy;
  logic [7:0] rdata;
  logic       rdata_vld;
  logic       ren, wen;
  logic [7:0] sub_addr, wdata, err_idx;
  logic       cfg_busy, cfg_done, cfg_err;

  logic       rdy_hold = 1'b0;
  logic       fail_3a  = 1'b0;
  logic [2:0] m_cnt;
  logic       m_rd;
  logic [7:0] m_addr;
  logic [7:0] mem [256];

  logic [16:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_wen  = 0;
  int n_ren  = 0;
  int t_w12  = 0;
  int t_w3a  = 0;
  int t_rel  = 0;

  sccb_cfg_ctrl #(
    .REG_NUM    (REG_NUM),
    .MS_CYC     (MS_CYC),
    .PWR_MS     (PWR_MS),
    .MAX_RETRY  (MAX_RETRY),
    .AUTO_START (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rdy       (rdy),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .ren       (ren),
    .wen       (wen),
    .sub_addr  (sub_addr),
    .wdata     (wdata),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_idx   (err_idx)
  );

  always #5 clk = ~clk;

  // SCCB master model: busy 4 cycles per transaction, read data returned at the end
  assign rdy = !rdy_hold && (m_cnt == 3'd0) && !wen && !ren;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= 3'd0;
      m_rd      <= 1'b0;
      m_addr    <= 8'd0;
      rdata     <= 8'd0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= 1'b0;
      if (wen) begin
        mem[sub_addr] <= wdata;
        m_cnt <= 3'd4;
        m_rd  <= 1'b0;
      end else if (ren) begin
        m_cnt  <= 3'd4;
        m_rd   <= 1'b1;
        m_addr <= sub_addr;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1 && m_rd) begin
          rdata_vld <= 1'b1;
          rdata     <= (fail_3a && m_addr == 8'h3A) ? 8'h00 : mem[m_addr];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (wen || ren) begin
      chk("req_exclusive", 32'(wen & ren), 32'd0);
      if (wen) begin
        n_wen++;
        if (sub_addr == 8'h12) t_w12 = cyc;
        if (sub_addr == 8'h3A && t_w3a == 0) t_w3a = cyc;
      end else begin
        n_ren++;
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL txn_unexpected: observed ren=%0b addr=0x%0h data=0x%0h expected none",
               ren, sub_addr, wdata);
      end
      if (exp_q.size() != 0) chk("txn", 32'({ren, sub_addr, wdata}), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic push(input logic rd, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({rd, a, d});
  endtask

  task automatic push_run(input int tries_3a);
    push(1'b0, 8'h12, 8'h80);
    for (int i = 0; i < tries_3a; i++) begin
      push(1'b0, 8'h3A, 8'h04);
      push(1'b1, 8'h3A, 8'h04);
    end
    push(1'b0, 8'h40, 8'hD0);
    push(1'b0, 8'h8C, 8'h00);
    push(1'b1, 8'h8C, 8'h00);
  endtask

  task automatic clr_stats();
    n_wen = 0; n_ren = 0; t_w12 = 0; t_w3a = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cfg_done && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(cfg_done), 32'd1);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_wen"},      32'(wen),      32'd0);
    chk({pfx, "_ren"},      32'(ren),      32'd0);
    chk({pfx, "_sub_addr"}, 32'(sub_addr), 32'd0);
    chk({pfx, "_wdata"},    32'(wdata),    32'd0);
    chk({pfx, "_busy"},     32'(cfg_busy), 32'd0);
    chk({pfx, "_done"},     32'(cfg_done), 32'd0);
    chk({pfx, "_err"},      32'(cfg_err),  32'd0);
    chk({pfx, "_err_idx"},  32'(err_idx),  32'd0);
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    chk_reset("rst");

    // run A: auto-start, all verifies pass, delay entry honoured
    clr_stats();
    push_run(1);
    rst_n = 1'b1;
    t_rel = cyc;
    wait_done("runA_done");
    chk("runA_q_empty", 32'(exp_q.size()), 32'd0);
    chk("runA_wen_cnt", 32'(n_wen), 32'd4);
    chk("runA_ren_cnt", 32'(n_ren), 32'd2);
    chk("runA_err", 32'(cfg_err), 32'd0);
    chk("runA_busy", 32'(cfg_busy), 32'd0);
    chk("pwr_dly_latency", 32'((t_w12 - t_rel) >= 21 && (t_w12 - t_rel) <= 28), 32'd1);
    chk("dly_entry_gap", 32'((t_w3a - t_w12) >= 21 && (t_w3a - t_w12) <= 40), 32'd1);

    // run B: read-back of 0x3A always mismatches, retries exhaust
    tick();
    clr_stats();
    fail_3a = 1'b1;
    push_run(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("runB_done_cleared", 32'(cfg_done), 32'd0);
    chk("runB_busy", 32'(cfg_busy), 32'd1);
    wait_done("runB_done");
    chk("runB_q_empty", 32'(exp_q.size()), 32'd0);
    chk("runB_wen_cnt", 32'(n_wen), 32'd6);
    chk("runB_ren_cnt", 32'(n_ren), 32'd4);
    chk("runB_err", 32'(cfg_err), 32'd1);
    chk("runB_err_idx", 32'(err_idx), 32'd2);
    fail_3a = 1'b0;

    // run C: rdy held low while a write is pending
    tick();
    clr_stats();
    push_run(1);
    rdy_hold = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (80) tick();
    chk("hold_no_wen", 32'(n_wen), 32'd0);
    chk("hold_sub_addr", 32'(sub_addr), 32'h12);
    chk("hold_wdata", 32'(wdata), 32'h80);
    rdy_hold = 1'b0;
    tick();
    chk("hold_release_wen", 32'(wen), 32'd1);
    tick();
    tick();

    // reset in WR_WAIT aborts; restart runs from idx 0, extra starts ignored
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    exp_q.delete();
    tick();
    tick();
    clr_stats();
    push_run(1);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("runD_done");
    chk("runD_q_empty", 32'(exp_q.size()), 32'd0);
    chk("runD_wen_cnt", 32'(n_wen), 32'd4);
    chk("runD_err", 32'(cfg_err), 32'd0);
    repeat (5) tick();
    chk("runD_idle_no_busy", 32'(cfg_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
